pheap_sift_ctrl: RTL and testbench

- Per-level controller for the pipelined heap. It drives the storage of its own level through the top port and reads child pairs from the next level's storage through the bottom port.
- It executes the sift-down half of REPLACE/DELETE. An entry arriving from level LEVEL-1 at index i is compared against children 2i and 2i+1. The smaller value is written at i and, if needed, the displaced entry is forwarded to level LEVEL+1.
- One instance per level, chained by valid/ready.

---
 rtl/pheap_sift_ctrl_pkg.sv | 33 +++
 rtl/pheap_min2.sv | 16 +
 rtl/pheap_sift_ctrl.sv | 141 ++++++++++++++
 tb/tb_pheap_sift_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pheap_sift_ctrl_pkg.sv
// Shared types for the pipelined heap: entry layout, controller states and
// the ordering rule that treats an invalid entry as +infinity.
package pheap_sift_ctrl_pkg;

    localparam int unsigned PrioW    = 8;
    localparam int unsigned PayloadW = 8;

    typedef struct packed {
        logic                valid;
        logic [PrioW-1:0]    prio;
        logic [PayloadW-1:0] payload;
    } entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCmp,
        StWr,
        StDn
    } op_state_t;

    // a <= b with invalid entries ordered above every valid one
    function automatic logic entry_le(input entry_t a, input entry_t b);
        if (!b.valid) begin
            return 1'b1;
        end
        if (!a.valid) begin
            return 1'b0;
        end
        return a.prio <= b.prio;
    endfunction

endpackage

// File: rtl/pheap_min2.sv
// Combinational child selector: smaller of two entries, left wins ties.
module pheap_min2
    import pheap_sift_ctrl_pkg::*;
(
    input  entry_t left_i,
    input  entry_t right_i,
    output entry_t min_o,
    output logic   side_o
);

    always_comb begin
        side_o = !entry_le(left_i, right_i);
        min_o  = side_o ? right_i : left_i;
    end

endmodule

// File: rtl/pheap_sift_ctrl.sv
// Per-level sift-down controller: compares an arriving entry with its two
// children, writes the winner into its own level and forwards the loser down.
module pheap_sift_ctrl
    import pheap_sift_ctrl_pkg::*;
#(
    parameter int unsigned LEVEL = 2,
    parameter int unsigned LAST  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  entry_t           inEntry,
    input  logic [LEVEL-2:0] inIdx,
    output logic             topActive,
    output logic             wenTop,
    output logic [LEVEL-2:0] wraddrTop,
    output entry_t           aTop,
    output logic             botReq,
    input  logic             botGnt,
    output logic [LEVEL-1:0] raddrBot,
    input  entry_t           yBotL,
    input  entry_t           yBotR,
    output logic             outValid,
    input  logic             outReady,
    output entry_t           outEntry,
    output logic [LEVEL-1:0] outIdx
);

    localparam bit IsLast = (LAST != 0);

    op_state_t        state_q, state_d;
    entry_t           x_q, x_d;
    logic [LEVEL-2:0] i_q, i_d;
    entry_t           winner_q, winner_d;
    logic             push_q, push_d;
    logic [LEVEL-1:0] out_idx_q, out_idx_d;

    entry_t child_min;
    logic   child_side;

    pheap_min2 u_min2 (
        .left_i  (yBotL),
        .right_i (yBotR),
        .min_o   (child_min),
        .side_o  (child_side)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        i_d       = i_q;
        winner_d  = winner_q;
        push_d    = push_q;
        out_idx_d = out_idx_q;

        inReady   = 1'b0;
        topActive = 1'b0;
        wenTop    = 1'b0;
        wraddrTop = '0;
        aTop      = '0;
        botReq    = 1'b0;
        raddrBot  = '0;
        outValid  = 1'b0;
        outEntry  = '0;
        outIdx    = '0;

        unique case (state_q)
            StIdle: begin
                inReady = 1'b1;
                if (inValid) begin
                    x_d = inEntry;
                    i_d = inIdx;
                    if (IsLast) begin
                        winner_d = inEntry;
                        push_d   = 1'b0;
                        state_d  = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                botReq   = 1'b1;
                raddrBot = {i_q, 1'b0};
                if (botGnt) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // Child data arrives one cycle after the grant, i.e. now.
                if (entry_le(x_q, child_min)) begin
                    winner_d = x_q;
                    push_d   = 1'b0;
                end else begin
                    winner_d  = child_min;
                    push_d    = 1'b1;
                    out_idx_d = {i_q, child_side};
                end
                state_d = StWr;
            end
            StWr: begin
                topActive = 1'b1;
                wenTop    = 1'b1;
                wraddrTop = i_q;
                aTop      = winner_q;
                state_d   = push_q ? StDn : StIdle;
            end
            StDn: begin
                outValid = 1'b1;
                outEntry = x_q;
                outIdx   = out_idx_q;
                if (outReady) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            i_q       <= '0;
            winner_q  <= '0;
            push_q    <= 1'b0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            i_q       <= i_d;
            winner_q  <= winner_d;
            push_q    <= push_d;
            out_idx_q <= out_idx_d;
        end
    end

endmodule

// File: tb/tb_pheap_sift_ctrl.sv
// Bench for pheap_sift_ctrl: an inner level (LEVEL=3) and a bottom level (LEVEL=4, LAST=1).
module tb_pheap_sift_ctrl;
    import pheap_sift_ctrl_pkg::*;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Inner level DUT
    logic       a_inValid = 1'b0, a_inReady;
    entry_t     a_inEntry = '0;
    logic [1:0] a_inIdx = '0;
    logic       a_topActive, a_wenTop;
    logic [1:0] a_wraddrTop;
    entry_t     a_aTop;
    logic       a_botReq, a_botGnt = 1'b0;
    logic [2:0] a_raddrBot;
    entry_t     a_yBotL = '0, a_yBotR = '0;
    logic       a_outValid, a_outReady = 1'b0;
    entry_t     a_outEntry;
    logic [2:0] a_outIdx;

    // Bottom level DUT
    logic       b_inValid = 1'b0, b_inReady;
    entry_t     b_inEntry = '0;
    logic [2:0] b_inIdx = '0;
    logic       b_topActive, b_wenTop;
    logic [2:0] b_wraddrTop;
    entry_t     b_aTop;
    logic       b_botReq, b_botGnt = 1'b0;
    logic [3:0] b_raddrBot;
    entry_t     b_yBotL = '0, b_yBotR = '0;
    logic       b_outValid, b_outReady = 1'b0;
    entry_t     b_outEntry;
    logic [3:0] b_outIdx;

    pheap_sift_ctrl #(.LEVEL(3), .LAST(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .inValid(a_inValid), .inReady(a_inReady), .inEntry(a_inEntry), .inIdx(a_inIdx),
        .topActive(a_topActive), .wenTop(a_wenTop), .wraddrTop(a_wraddrTop), .aTop(a_aTop),
        .botReq(a_botReq), .botGnt(a_botGnt), .raddrBot(a_raddrBot),
        .yBotL(a_yBotL), .yBotR(a_yBotR),
        .outValid(a_outValid), .outReady(a_outReady), .outEntry(a_outEntry), .outIdx(a_outIdx)
    );

    pheap_sift_ctrl #(.LEVEL(4), .LAST(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .inValid(b_inValid), .inReady(b_inReady), .inEntry(b_inEntry), .inIdx(b_inIdx),
        .topActive(b_topActive), .wenTop(b_wenTop), .wraddrTop(b_wraddrTop), .aTop(b_aTop),
        .botReq(b_botReq), .botGnt(b_botGnt), .raddrBot(b_raddrBot),
        .yBotL(b_yBotL), .yBotR(b_yBotR),
        .outValid(b_outValid), .outReady(b_outReady), .outEntry(b_outEntry), .outIdx(b_outIdx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input bit v, input int p, input int pl);
        entry_t e;
        e.valid   = v;
        e.prio    = p[7:0];
        e.payload = pl[7:0];
        return e;
    endfunction

    function automatic entry_t rand_entry();
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 255));
    endfunction

    // Invalid counts as 256, above any 8-bit priority.
    function automatic int key(input entry_t e);
        return e.valid ? int'(e.prio) : 256;
    endfunction

    task automatic model(input entry_t x, input entry_t cl, input entry_t cr, input int idx,
                         output entry_t win, output bit push, output int oidx);
        entry_t c;
        int     side;
        if (key(cl) <= key(cr)) begin c = cl; side = 0; end
        else begin c = cr; side = 1; end
        if (key(x) <= key(c)) begin win = x; push = 0; end
        else begin win = c; push = 1; end
        oidx = 2 * idx + side;
    endtask

    // Decoy child data outside the read-data cycle: valid, prio 0.
    entry_t junk;

    task automatic op3(input entry_t x, input int idx, input entry_t cl, input entry_t cr,
                       input int gstall, input int rstall, input bit hold);
        entry_t win;
        bit     push;
        int     oidx;
        model(x, cl, cr, idx, win, push, oidx);
        chk("idle_ready", a_inReady, 1);
        a_inValid = 1'b1;
        a_inEntry = x;
        a_inIdx   = idx[1:0];
        @(negedge clk);
        if (!hold) a_inValid = 1'b0;
        repeat (gstall) begin
            chk("rd_stall_req", a_botReq, 1);
            chk("rd_stall_addr", a_raddrBot, 2 * idx);
            @(negedge clk);
        end
        chk("rd_req", a_botReq, 1);
        chk("rd_addr", a_raddrBot, 2 * idx);
        chk("rd_busy", a_inReady, 0);
        chk("rd_nowrite", a_wenTop, 0);
        a_botGnt = 1'b1;
        @(posedge clk);
        #1;
        a_botGnt = 1'b0;
        a_yBotL  = cl;
        a_yBotR  = cr;
        @(negedge clk);
        chk("cmp_noreq", a_botReq, 0);
        chk("cmp_nowrite", a_wenTop, 0);
        @(posedge clk);
        #1;
        a_yBotL = junk;
        a_yBotR = junk;
        @(negedge clk);
        chk("wr_en", a_wenTop, 1);
        chk("wr_top", a_topActive, 1);
        chk("wr_addr", a_wraddrTop, idx);
        chk("wr_data", a_aTop, win);
        chk("wr_noout", a_outValid, 0);
        if (push) begin
            @(negedge clk);
            repeat (rstall) begin
                chk("dn_hold_valid", a_outValid, 1);
                chk("dn_hold_entry", a_outEntry, x);
                chk("dn_hold_idx", a_outIdx, oidx);
                chk("dn_busy", a_inReady, 0);
                @(negedge clk);
            end
            chk("dn_valid", a_outValid, 1);
            chk("dn_entry", a_outEntry, x);
            chk("dn_idx", a_outIdx, oidx);
            chk("dn_notop", a_topActive, 0);
            a_outReady = 1'b1;
        end
        a_inValid = 1'b0;
        @(negedge clk);
        a_outReady = 1'b0;
        chk("end_idle", a_inReady, 1);
        chk("end_noout", a_outValid, 0);
        chk("end_noreq", a_botReq, 0);
        chk("end_nowrite", a_wenTop, 0);
    endtask

    task automatic opb(input entry_t x, input int idx);
        chk("b_idle", b_inReady, 1);
        b_inValid = 1'b1;
        b_inEntry = x;
        b_inIdx   = idx[2:0];
        @(negedge clk);
        b_inValid = 1'b0;
        chk("b_wr_en", b_wenTop, 1);
        chk("b_wr_addr", b_wraddrTop, idx);
        chk("b_wr_data", b_aTop, x);
        chk("b_noreq", b_botReq, 0);
        chk("b_noout", b_outValid, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        entry_t x2;
        junk = mk(1, 0, 8'hEE);
        a_yBotL = junk;
        a_yBotR = junk;
        repeat (2) @(negedge clk);
        chk("rst_ready", a_inReady, 1);
        chk("rst_wen", a_wenTop, 0);
        chk("rst_top", a_topActive, 0);
        chk("rst_req", a_botReq, 0);
        chk("rst_out", a_outValid, 0);
        chk("rst_outentry", a_outEntry, 0);
        chk("rst_b_ready", b_inReady, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while reading children
        a_inValid = 1'b1;
        a_inEntry = mk(1, 3, 1);
        a_inIdx   = 2'd2;
        @(negedge clk);
        a_inValid = 1'b0;
        chk("midrd_req", a_botReq, 1);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_req", a_botReq, 0);
        chk("midrd_rst_wen", a_wenTop, 0);
        chk("midrd_rst_ready", a_inReady, 1);
        chk("midrd_rst_addr", a_raddrBot, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrd_after_ready", a_inReady, 1);
        chk("midrd_after_req", a_botReq, 0);

        // Directed cases
        op3(mk(1, 5, 8'h11), 1, mk(1, 7, 8'h21), mk(1, 9, 8'h22), 0, 0, 0);
        op3(mk(1, 8, 8'h12), 2, mk(1, 3, 8'h23), mk(1, 6, 8'h24), 0, 0, 1);
        op3(mk(1, 6, 8'h13), 3, mk(1, 4, 8'h25), mk(1, 4, 8'h26), 0, 0, 0);
        op3(mk(1, 6, 8'h14), 0, mk(1, 6, 8'h27), mk(1, 9, 8'h28), 0, 0, 1);
        op3(mk(0, 0, 8'h00), 1, mk(0, 0, 8'h29), mk(1, 2, 8'h2A), 5, 4, 1);
        op3(mk(0, 7, 8'h15), 2, mk(0, 1, 8'h2B), mk(0, 3, 8'h2C), 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            op3(rand_entry(), $urandom_range(0, 3), rand_entry(), rand_entry(),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        // Bottom level: one-cycle latency, held inValid waits for inReady
        chk("b_idle0", b_inReady, 1);
        b_inValid = 1'b1;
        b_inEntry = mk(1, 11, 8'h31);
        b_inIdx   = 3'd6;
        @(negedge clk);
        x2 = mk(1, 12, 8'h32);
        b_inEntry = x2;
        b_inIdx   = 3'd3;
        chk("b1_wr_en", b_wenTop, 1);
        chk("b1_wr_addr", b_wraddrTop, 6);
        chk("b1_wr_data", b_aTop, mk(1, 11, 8'h31));
        chk("b1_busy", b_inReady, 0);
        chk("b1_noreq", b_botReq, 0);
        chk("b1_noout", b_outValid, 0);
        @(negedge clk);
        chk("b1_back_idle", b_inReady, 1);
        chk("b1_no_second_write", b_wenTop, 0);
        @(negedge clk);
        b_inValid = 1'b0;
        chk("b2_wr_en", b_wenTop, 1);
        chk("b2_wr_addr", b_wraddrTop, 3);
        chk("b2_wr_data", b_aTop, x2);
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            opb(rand_entry(), $urandom_range(0, 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
